// File: rtl/seven_seg_scan_n.sv
// N-digit multiplexed seven-segment scanner with guard interval, PWM brightness,
// per-digit enable/blink and registered, glitch-free outputs.
module seven_seg_scan_n #(
    parameter int DIGITS       = 8,
    parameter int TICK_DIV     = 25000,
    parameter int GUARD        = 500,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 250
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7*DIGITS-1:0]         seg_in,
    input  logic [DIGITS-1:0]           dp_in,
    input  logic [DIGITS-1:0]           en_in,
    input  logic [DIGITS-1:0]           blink_in,
    input  logic [BRIGHT_W-1:0]         brightness,
    output logic [DIGITS-1:0]           an,
    output logic [6:0]                  seg_out,
    output logic                        dp_out,
    output logic [$clog2(DIGITS)-1:0]   digit_idx,
    output logic                        frame_tick
);
    localparam int CW   = $clog2(TICK_DIV);
    localparam int DW   = $clog2(DIGITS);
    localparam int FW   = $clog2(BLINK_FRAMES + 1);
    localparam int ON_W = CW + BRIGHT_W + 1;

    logic [DIGITS-1:0][6:0] seg_arr;
    assign seg_arr = seg_in;

    logic [CW-1:0]       slot_cnt;
    logic [DW-1:0]       digit_cnt;
    logic [FW-1:0]       blink_cnt;
    logic                blink_phase;
    logic [BRIGHT_W-1:0] bright_q;
    logic [6:0]          seg_sh;
    logic                dp_sh, en_sh, blink_sh;

    logic slot_first, slot_last, digit_last, frame_first, frame_last;
    assign slot_first  = (slot_cnt == '0);
    assign slot_last   = (slot_cnt == CW'(TICK_DIV - 1));
    assign digit_last  = (digit_cnt == DW'(DIGITS - 1));
    assign frame_first = slot_first && (digit_cnt == '0);
    assign frame_last  = slot_last && digit_last;

    // Product is kept at full width so the duty fraction is exact before the shift.
    logic [ON_W-1:0] on_len, on_end, slot_ext;
    logic            in_on, lit;
    assign on_len   = (ON_W'(TICK_DIV - GUARD) * (ON_W'(bright_q) + ON_W'(1))) >> BRIGHT_W;
    assign on_end   = ON_W'(GUARD) + on_len;
    assign slot_ext = ON_W'(slot_cnt);
    assign in_on    = (slot_ext >= ON_W'(GUARD)) && (slot_ext < on_end);
    assign lit      = in_on && en_sh && !(blink_sh && blink_phase);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt    <= '0;
            digit_cnt   <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            bright_q    <= '0;
            seg_sh      <= '0;
            dp_sh       <= 1'b0;
            en_sh       <= 1'b0;
            blink_sh    <= 1'b0;
        end else begin
            slot_cnt <= slot_last ? '0 : slot_cnt + CW'(1);
            if (slot_last)
                digit_cnt <= digit_last ? '0 : digit_cnt + DW'(1);
            if (frame_last) begin
                if (blink_cnt == FW'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + FW'(1);
                end
            end
            // Slot 0 is always guard time, so the shadow settles before it is used.
            if (slot_first) begin
                seg_sh   <= seg_arr[digit_cnt];
                dp_sh    <= dp_in[digit_cnt];
                en_sh    <= en_in[digit_cnt];
                blink_sh <= blink_in[digit_cnt];
            end
            if (frame_first)
                bright_q <= brightness;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= '1;
            seg_out    <= 7'h7F;
            dp_out     <= 1'b1;
            digit_idx  <= '0;
            frame_tick <= 1'b0;
        end else begin
            an         <= lit ? ~(DIGITS'(1) << digit_cnt) : '1;
            seg_out    <= lit ? seg_sh : 7'h7F;
            dp_out     <= lit ? dp_sh : 1'b1;
            digit_idx  <= digit_cnt;
            frame_tick <= frame_first;
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_n.sv
// Directed bench for seven_seg_scan_n: scan order, brightness, enable, blink,
// shadowing and asynchronous reset on a 4-digit, 64-cycle frame.
module tb_seven_seg_scan_n;
    localparam int DIGITS = 4, TICK_DIV = 16, GUARD = 2, BRIGHT_W = 2, BLINK_FRAMES = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [27:0] seg_in;
    logic [3:0]  dp_in, en_in, blink_in;
    logic [1:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    seven_seg_scan_n #(
        .DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .GUARD(GUARD),
        .BRIGHT_W(BRIGHT_W), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dp_in(dp_in), .en_in(en_in),
        .blink_in(blink_in), .brightness(brightness), .an(an), .seg_out(seg_out),
        .dp_out(dp_out), .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    int          n_tests = 0, n_fail = 0;
    logic [6:0]  exp_seg [4];
    int          low_cnt [4];
    int          first_on[4];
    int          seg_bad, order_bad, tick_bad, idx_bad;
    logic [1:0]  nxt_bright;
    logic [27:0] nxt_seg;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Runs one 64-cycle frame starting on its frame_tick cycle; optional input change at step chg_at.
    task automatic run_frame(input int chg_at);
        logic [3:0] exp_an;
        int d, s;
        seg_bad = 0; order_bad = 0; tick_bad = 0; idx_bad = 0;
        for (int k = 0; k < 4; k++) begin
            low_cnt[k]  = 0;
            first_on[k] = -1;
        end
        for (int i = 0; i < 64; i++) begin
            if (i == chg_at) begin
                brightness = nxt_bright;
                seg_in     = nxt_seg;
            end
            step();
            d = i / 16;
            s = i % 16;
            exp_an = ~(4'b0001 << d);
            if (frame_tick !== (i == 0)) tick_bad++;
            if (digit_idx !== 2'(d)) idx_bad++;
            if (an === 4'hF) begin
                if (seg_out !== 7'h7F || dp_out !== 1'b1) seg_bad++;
            end else if (an === exp_an) begin
                low_cnt[d]++;
                if (first_on[d] < 0) first_on[d] = s;
                if (seg_out !== exp_seg[d] || dp_out !== dp_in[d]) seg_bad++;
            end else begin
                order_bad++;
            end
        end
    endtask

    task automatic frame_chk(input string tag, input int l0, input int l1, input int l2, input int l3);
        int l[4];
        l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s low_cnt[%0d]", tag, k), low_cnt[k], l[k]);
            chk($sformatf("%s first_on[%0d]", tag, k), first_on[k], (l[k] == 0) ? -1 : GUARD);
        end
        chk({tag, " seg_bad"}, seg_bad, 0);
        chk({tag, " order_bad"}, order_bad, 0);
        chk({tag, " tick_bad"}, tick_bad, 0);
        chk({tag, " idx_bad"}, idx_bad, 0);
    endtask

    initial begin
        seg_in     = {7'h08, 7'h04, 7'h02, 7'h01};
        dp_in      = 4'b1010;
        en_in      = 4'b1111;
        blink_in   = 4'b0000;
        brightness = 2'd3;
        exp_seg[0] = 7'h01; exp_seg[1] = 7'h02; exp_seg[2] = 7'h04; exp_seg[3] = 7'h08;
        nxt_bright = brightness;
        nxt_seg    = seg_in;

        // Reset state while rst is held
        step();
        step();
        chk("rst an", an, 4'hF);
        chk("rst seg_out", seg_out, 7'h7F);
        chk("rst dp_out", dp_out, 1'b1);
        chk("rst frame_tick", frame_tick, 1'b0);
        chk("rst digit_idx", digit_idx, 2'd0);
        rst = 1'b0;

        // Scan order, full brightness
        run_frame(-1);
        frame_chk("scan", 14, 14, 14, 14);

        // Brightness: 0, then switch to 1 mid-frame; new window only from next frame
        brightness = 2'd0;
        do_reset();
        run_frame(-1);
        frame_chk("bright0", 3, 3, 3, 3);
        nxt_bright = 2'd1;
        nxt_seg    = seg_in;
        run_frame(30);
        frame_chk("bright_mid", 3, 3, 3, 3);
        run_frame(-1);
        frame_chk("bright1", 7, 7, 7, 7);

        // Enable: digit 2 dark, frame length unchanged
        brightness = 2'd3;
        en_in      = 4'b1011;
        do_reset();
        run_frame(-1);
        frame_chk("en f0", 14, 14, 0, 14);
        run_frame(-1);
        frame_chk("en f1", 14, 14, 0, 14);

        // Blink: digit 1 lit 2 frames, dark 2 frames, lit again
        en_in    = 4'b1111;
        blink_in = 4'b0010;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            run_frame(-1);
            frame_chk($sformatf("blink f%0d", f), 14, ((f / 2) % 2 == 0) ? 14 : 0, 14, 14);
        end

        // Shadowing: digit 3 changes mid-ON; old value holds until the next frame
        blink_in = 4'b0000;
        do_reset();
        run_frame(-1);
        frame_chk("shadow f0", 14, 14, 14, 14);
        nxt_bright = brightness;
        nxt_seg    = {7'h40, seg_in[20:0]};
        run_frame(56);
        frame_chk("shadow f1", 14, 14, 14, 14);
        exp_seg[3] = 7'h40;
        run_frame(-1);
        frame_chk("shadow f2", 14, 14, 14, 14);

        // Asynchronous reset during digit 2's ON window
        do_reset();
        for (int i = 0; i < 38; i++) step();
        chk("pre-async an", an, 4'b1011);
        chk("pre-async seg_out", seg_out, 7'h04);
        #2 rst = 1'b1;
        #1;
        chk("async an", an, 4'hF);
        chk("async seg_out", seg_out, 7'h7F);
        chk("async dp_out", dp_out, 1'b1);
        chk("async digit_idx", digit_idx, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post c1 frame_tick", frame_tick, 1'b1);
        chk("post c1 an", an, 4'hF);
        step();
        chk("post c2 frame_tick", frame_tick, 1'b0);
        chk("post c2 an", an, 4'hF);
        step();
        chk("post c3 an", an, 4'b1110);
        chk("post c3 seg_out", seg_out, 7'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
